// File: rtl/md_cart_responder.sv
// Cartridge-side bus responder: strobe decode, 8-slot bank mapper, SRAM window, req/ack memory port.
// Optional MD_CART_EXT_DTACK_EN drives ext_dtack from the access FSM; otherwise ext_dtack is tied 0.
module md_cart_responder #(
  parameter int unsigned BANK_BITS      = 6,
  parameter int unsigned SRAM_AW        = 15,
  parameter int unsigned SRAM_BASE_SLOT = 4
) (
  input  logic                  MCLK,
  input  logic                  reset_n,
  input  logic [22:0]           cart_address,
  input  logic                  cart_cs,
  input  logic                  cart_oe,
  input  logic                  cart_lwr,
  input  logic                  cart_uwr,
  input  logic                  cart_time,
  input  logic [15:0]           cart_data_wr,
  output logic [15:0]           cart_data,
  output logic                  cart_data_en,
  output logic                  ext_dtack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_sram,
  output logic [BANK_BITS+17:0] mem_addr,
  output logic [1:0]            mem_be,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_ack
);

  localparam int unsigned AW = BANK_BITS + 18;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_HOLD, WR_REQ, WR_HOLD} state_t;

  state_t            state_q, state_d;
  logic              rd, wr, tw, rd_q, wr_q, tw_q;
  logic              in_range, sram_hit, reg_wr;
  logic [2:0]        slot, idx;
  logic [AW-1:0]     hit_addr;
  logic              sram_en_q, sram_wp_q;
  logic [BANK_BITS-1:0] bank_q [8];

  logic              mem_req_d, mem_we_d, mem_sram_d, cart_data_en_d;
  logic [AW-1:0]     mem_addr_d;
  logic [1:0]        mem_be_d;
  logic [15:0]       mem_wdata_d, cart_data_d;

  // Strobe decode and address mapping
  always_comb begin
    rd       = cart_cs & cart_oe;
    wr       = cart_cs & (cart_lwr | cart_uwr);
    tw       = cart_time & cart_lwr;
    slot     = cart_address[20:18];
    idx      = cart_address[2:0];
    in_range = (cart_address[22:21] == 2'b00);
    sram_hit = sram_en_q && (32'(slot) >= SRAM_BASE_SLOT);
    hit_addr = sram_hit ? AW'(cart_address[SRAM_AW-1:0])
                        : {bank_q[slot], cart_address[17:0]};
    // a simultaneous cart access takes precedence over the register write
    reg_wr   = tw && !tw_q && (cart_address[6:3] == 4'hF) && !cart_cs;
  end

  // Previous-cycle strobe copies for edge detection
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      tw_q <= 1'b0;
    end else begin
      rd_q <= rd;
      wr_q <= wr;
      tw_q <= tw;
    end
  end

  // Mapper and SRAM control registers; bank 0 is never written
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      sram_en_q <= 1'b0;
      sram_wp_q <= 1'b0;
      for (int i = 0; i < 8; i++) bank_q[i] <= BANK_BITS'(i);
    end else if (reg_wr) begin
      if (idx == 3'd0) begin
        sram_en_q <= cart_data_wr[0];
        sram_wp_q <= cart_data_wr[1];
      end else begin
        bank_q[idx] <= cart_data_wr[BANK_BITS-1:0];
      end
    end
  end

  // Access FSM next-state and output values
  always_comb begin
    state_d        = state_q;
    mem_req_d      = mem_req;
    mem_we_d       = mem_we;
    mem_sram_d     = mem_sram;
    mem_addr_d     = mem_addr;
    mem_be_d       = mem_be;
    mem_wdata_d    = mem_wdata;
    cart_data_d    = cart_data;
    cart_data_en_d = cart_data_en;
    case (state_q)
      IDLE: begin
        if (rd && !rd_q && in_range) begin
          state_d    = RD_REQ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_sram_d = sram_hit;
          mem_addr_d = hit_addr;
          mem_be_d   = 2'b11;
        end else if (wr && !wr_q && in_range) begin
          if (sram_hit && !sram_wp_q) begin
            state_d     = WR_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_sram_d  = 1'b1;
            mem_addr_d  = hit_addr;
            mem_be_d    = {cart_uwr, cart_lwr};
            mem_wdata_d = cart_data_wr;
          end else begin
            state_d = WR_HOLD;
          end
        end
      end
      RD_REQ: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          cart_data_d = mem_rdata;
          if (rd_q) begin
            state_d        = RD_HOLD;
            cart_data_en_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RD_HOLD: begin
        if (!rd_q) begin
          state_d        = IDLE;
          cart_data_en_d = 1'b0;
        end
      end
      WR_REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = WR_HOLD;
        end
      end
      WR_HOLD: begin
        if (!wr_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_sram     <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= 2'b00;
      mem_wdata    <= 16'h0000;
      cart_data    <= 16'h0000;
      cart_data_en <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req      <= mem_req_d;
      mem_we       <= mem_we_d;
      mem_sram     <= mem_sram_d;
      mem_addr     <= mem_addr_d;
      mem_be       <= mem_be_d;
      mem_wdata    <= mem_wdata_d;
      cart_data    <= cart_data_d;
      cart_data_en <= cart_data_en_d;
    end
  end

`ifdef MD_CART_EXT_DTACK_EN
  logic nomem_q, nomem_d, ext_dtack_d;

  // nomem tracks a WR_HOLD entered straight from IDLE (discarded write)
  always_comb begin
    nomem_d     = (state_d == WR_HOLD) && ((state_q == IDLE) || nomem_q);
    ext_dtack_d = (state_d == RD_HOLD) || ((state_q == WR_REQ) && mem_ack) || nomem_d;
  end

  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      nomem_q   <= 1'b0;
      ext_dtack <= 1'b0;
    end else begin
      nomem_q   <= nomem_d;
      ext_dtack <= ext_dtack_d;
    end
  end
`else
  assign ext_dtack = 1'b0;
`endif

endmodule

// File: doc/md_cart_responder.md
Name: md_cart_responder

Overview:
- Cartridge-side responder for the console cartridge bus; the console board is the initiator.
- Decodes the board's cart strobes and address, and drives read data back with a data-valid enable.
- Provides an 8-slot bank mapper and battery-SRAM window, programmed through TIME-region writes.
- Forwards every ROM/SRAM access to a backing memory over a req/ack handshake.

Parameters:
- BANK_BITS, 6: width of each bank register; physical ROM space is 2^(BANK_BITS+18) words.
- SRAM_AW, 15: SRAM word-address width.
- SRAM_BASE_SLOT, 4: cart slot (512 KB units) where the SRAM window appears when enabled.

Ports:
- MCLK  in  1  system clock; all cart inputs are synchronous to it.
- reset_n  in  1  asynchronous active-low reset.
- cart_address  in  23  68k word address A23..A1.
- cart_cs  in  1  cart ROM region select, active high.
- cart_oe  in  1  read strobe, active high.
- cart_lwr  in  1  lower-byte write strobe, active high.
- cart_uwr  in  1  upper-byte write strobe, active high.
- cart_time  in  1  $A130xx register region select, active high.
- cart_data_wr  in  16  write data from the board.
- cart_data  out  16  read data to the board.
- cart_data_en  out  1  cart_data valid; the board samples the data bus while this is high.
- ext_dtack  out  1  high forces DTACK asserted (optional feature only).
- mem_req  out  1  memory request, level.
- mem_we  out  1  1 = write, 0 = read.
- mem_sram  out  1  1 = SRAM space, 0 = ROM space.
- mem_addr  out  BANK_BITS+18  physical word address.
- mem_be  out  2  byte enables {upper, lower}.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse.

Behaviour:
- Reset values:
  - All outputs 0.
  - Bank register n resets to n (identity map).
  - sram_en = 0, sram_wp = 0, FSM = IDLE.
- Input registration:
  - All cart inputs pass through one register stage (prev copies).
  - Access starts on a 0→1 edge of rd = cs&oe or wr = cs&(lwr|uwr).
- Region decode: slot = cart_address[20:18]. Any address with cart_address[22:21] != 0 is ignored.
- SRAM hit:
  - Condition: sram_en & slot >= SRAM_BASE_SLOT.
  - mem_sram = 1, mem_addr = cart_address[SRAM_AW-1:0] zero-extended.
- ROM hit: mem_addr = {bank[slot], cart_address[17:0]}, mem_sram = 0.
- Register writes:
  - Trigger: rising edge of cart_time & cart_lwr with cart_address[6:3] = 4'hF (byte $A130F1..$A130FF). Completes in a single cycle; no memory traffic.
  - Index = cart_address[2:0].
  - Index 0: sram_en = data[0], sram_wp = data[1].
  - Index 1..7: bank[index] = data[BANK_BITS-1:0].
  - Bank 0 is read-only and always 0.
  - If cart_cs is also high in the same cycle, the cs access wins and the register write is dropped.
- FSM states: IDLE, RD_REQ, RD_HOLD, WR_REQ, WR_HOLD.
  - IDLE, rd edge → RD_REQ: mem_req = 1, mem_we = 0, mem_be = 2'b11.
  - IDLE, wr edge:
    - SRAM hit & ~sram_wp → WR_REQ: mem_be = {uwr, lwr}, mem_wdata = cart_data_wr.
    - Otherwise → WR_HOLD. ROM writes and protected SRAM writes are discarded.
  - RD_REQ, mem_ack:
    - Latch mem_rdata into cart_data and drop mem_req.
    - Strobe still high → RD_HOLD with cart_data_en = 1 from the next cycle (read latency = memory latency + 1).
    - Strobe already released → IDLE; data is discarded and cart_data_en never rises.
  - RD_HOLD: cart_data_en stays high until the registered rd falls, then cart_data_en = 0 and → IDLE. cart_data holds its last value.
  - WR_REQ, mem_ack → drop mem_req, → WR_HOLD.
  - WR_HOLD → IDLE once the registered wr is 0.
- Handshake rules:
  - mem_addr, mem_we, mem_sram, mem_be and mem_wdata are stable for as long as mem_req is high.
  - mem_req never drops before mem_ack.
  - A strobe released mid-request does not abort the request.
- mem_ack in IDLE/HOLD states is ignored.
- Reset asserted mid-operation clears mem_req immediately; an ack arriving afterwards is ignored.

Optional Feature:
- Macro: MD_CART_EXT_DTACK_EN.
- Enabled:
  - ext_dtack = 1 in RD_HOLD and for 1 cycle after the WR_REQ ack.
  - ext_dtack = 1 in WR_HOLD entered without a memory request.
  - ext_dtack = 0 otherwise; cleared on reset.
- Disabled: ext_dtack is constant 0; the board's own DTACK timing applies and the backing memory must respond in time.

Test Plan:
- Reset, then read word address 0x000010 with mem_ack 3 cycles later returning 0x4E71 → mem_addr = 0x000010, mem_sram = 0, cart_data = 0x4E71, cart_data_en high until cart_oe falls.
- TIME write of data 0x0009 at word address 0x509879 ($A130F3), then read word address 0x040002 → mem_addr = 0x240002.
- TIME write of 0x0001 at word address 0x509878 ($A130F1), then uwr-only write of 0xAB00 to word address 0x100005 → mem_sram = 1, mem_addr = 0x000005, mem_be = 2'b10.
- Write 0x0003 to $A130F1 (SRAM enabled, write-protected), then write to the SRAM window → no mem_req; a read from the same address still returns SRAM data.
- Drop cart_oe during RD_REQ, ack 5 cycles later → mem_req drops on the ack, cart_data_en stays 0, FSM returns to IDLE.
- Assert reset_n = 0 during RD_REQ, then deliver mem_ack → all outputs 0, bank registers return to identity, no cart_data_en pulse.
